// File: rtl/branch_pred_unit_if.sv
// IF/EX pipeline-facing signals of the branch prediction unit.
// The pipeline drives through the master modport; the predictor uses slave.
interface branch_pred_unit_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   if_pc;
    logic              if_is_branch;
    logic              pred_taken;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic              ex_is_branch;
    logic              ex_is_jalr;
    logic [2:0]        ex_funct3;
    logic              ex_pred_taken;
    logic              BrEq;
    logic              BrLt;
    logic [1:0]        PCSel;
    logic              flush;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, if_is_branch, ex_valid, ex_pc, ex_is_branch, ex_is_jalr,
               ex_funct3, ex_pred_taken, BrEq, BrLt, stat_clr,
        input  pred_taken, PCSel, flush, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, if_is_branch, ex_valid, ex_pc, ex_is_branch, ex_is_jalr,
               ex_funct3, ex_pred_taken, BrEq, BrLt, stat_clr,
        output pred_taken, PCSel, flush, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_pred_unit.sv
// Bimodal branch predictor: direct-mapped 2-bit counters looked up in IF,
// resolved and trained in EX, with next-PC select, flush and statistics.
module branch_pred_unit #(
    parameter int         XLEN     = 32,
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_pred_unit_if.slave bp
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          cnt_q [ENTRIES];
    logic [1:0]          cnt_d [ENTRIES];
    logic [STAT_W-1:0]   stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0]   stat_mispredicts_q, stat_mispredicts_d;

    logic [XLEN-1:0]     if_pc_w, ex_pc_w;
    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic                resolve, taken, mispredict, lookup_taken;
    logic [1:0]          pc_sel;
    logic                unused_pc_bits;

    always_comb begin
        if_pc_w        = bp.if_pc;
        ex_pc_w        = bp.ex_pc;
        rd_idx         = if_pc_w[IDX_BITS+1:2];
        wr_idx         = ex_pc_w[IDX_BITS+1:2];
        unused_pc_bits = ^{if_pc_w[XLEN-1:IDX_BITS+2], if_pc_w[1:0],
                           ex_pc_w[XLEN-1:IDX_BITS+2], ex_pc_w[1:0]};
    end

    always_comb begin
        taken = 1'b0;
        case (bp.ex_funct3)
            3'b000:         taken = bp.BrEq;
            3'b001:         taken = ~bp.BrEq;
            3'b100, 3'b110: taken = bp.BrLt;
            3'b101, 3'b111: taken = ~bp.BrLt;
            default:        taken = 1'b0;
        endcase
        resolve      = bp.ex_valid & bp.ex_is_branch;
        mispredict   = resolve & (taken != bp.ex_pred_taken);
        lookup_taken = bp.if_is_branch & cnt_q[rd_idx][1];
    end

    // EX redirects outrank the IF prediction; reset forces the fall-through path.
    always_comb begin
        pc_sel = 2'b00;
        if (!rst_n)                         pc_sel = 2'b00;
        else if (bp.ex_valid & bp.ex_is_jalr) pc_sel = 2'b10;
        else if (mispredict)                pc_sel = taken ? 2'b10 : 2'b11;
        else if (lookup_taken)              pc_sel = 2'b01;
        bp.PCSel            = pc_sel;
        bp.flush            = pc_sel[1];
        bp.pred_taken       = rst_n & lookup_taken;
        bp.stat_branches    = stat_branches_q;
        bp.stat_mispredicts = stat_mispredicts_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (resolve) begin
            if (taken) cnt_d[wr_idx] = (cnt_q[wr_idx] == 2'b11) ? 2'b11 : cnt_q[wr_idx] + 2'b01;
            else       cnt_d[wr_idx] = (cnt_q[wr_idx] == 2'b00) ? 2'b00 : cnt_q[wr_idx] - 2'b01;
        end
    end

    always_comb begin
        if (bp.stat_clr) begin
            stat_branches_d    = '0;
            stat_mispredicts_d = '0;
        end else begin
            stat_branches_d    = stat_branches_q + STAT_W'(resolve);
            stat_mispredicts_d = stat_mispredicts_q + STAT_W'(mispredict);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            cnt_q              <= cnt_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end
endmodule

// File: tb/tb_branch_pred_unit.sv
// Scenario-driven bench for branch_pred_unit with a 4-bit statistics width.
// Observed bundle: {pred_taken, PCSel, flush, stat_branches, stat_mispredicts}.
module tb_branch_pred_unit;
    logic clk;
    logic rst_n;

    branch_pred_unit_if #(.XLEN(32), .STAT_W(4)) bif ();

    branch_pred_unit #(
        .XLEN(32), .IDX_BITS(6), .CNT_INIT(2'b01), .STAT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         passed;
    int         total;
    logic [3:0] e_br;
    logic [3:0] e_mis;

    function automatic logic [11:0] pk(logic p, logic [1:0] s, logic f, logic [3:0] b, logic [3:0] m);
        return {p, s, f, b, m};
    endfunction

    function automatic logic [11:0] obs();
        return {bif.pred_taken, bif.PCSel, bif.flush, bif.stat_branches, bif.stat_mispredicts};
    endfunction

    function automatic logic exp_taken(logic [2:0] f3, logic eq, logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        bif.if_pc = '0; bif.if_is_branch = 0; bif.ex_valid = 0; bif.ex_pc = '0;
        bif.ex_is_branch = 0; bif.ex_is_jalr = 0; bif.ex_funct3 = '0;
        bif.ex_pred_taken = 0; bif.BrEq = 0; bif.BrLt = 0; bif.stat_clr = 0;
    endtask

    task automatic set_if(logic [31:0] pc, logic br);
        bif.if_pc = pc; bif.if_is_branch = br;
    endtask

    task automatic set_ex(logic v, logic [31:0] pc, logic br, logic jalr, logic [2:0] f3,
                          logic pred, logic eq, logic lt);
        bif.ex_valid = v; bif.ex_pc = pc; bif.ex_is_branch = br; bif.ex_is_jalr = jalr;
        bif.ex_funct3 = f3; bif.ex_pred_taken = pred; bif.BrEq = eq; bif.BrLt = lt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick();
        set_if(32'h100, 1);
        set_ex(1, 32'h100, 1, 1, 3'b000, 0, 1, 0);
        sb.push_back('{name: "reset_forced", val: pk(0, 2'b00, 0, 0, 0)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        rst_n = 1;
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "reset_lookup", val: pk(0, 2'b00, 0, 0, 0)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br = 0; e_mis = 0;
    endtask

    task automatic test_training();
        for (int k = 0; k < 3; k++) begin
            idle();
            set_ex(1, 32'h100, 1, 0, 3'b000, 0, 1, 0);
            sb.push_back('{name: "train_mispredict", val: pk(0, 2'b10, 1, e_br, e_mis)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
            e_br++; e_mis++;
        end
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "train_lookup", val: pk(1, 2'b01, 0, 4'd3, 4'd3)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        // a correctly predicted taken branch on a saturated entry
        idle();
        set_ex(1, 32'h100, 1, 0, 3'b000, 1, 1, 0);
        sb.push_back('{name: "train_saturate", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br++;
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "train_sat_lookup", val: pk(1, 2'b01, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
    endtask

    task automatic test_recovery();
        // counter 11 -> 10 still predicts taken, 10 -> 01 does not
        for (int k = 0; k < 2; k++) begin
            idle();
            set_if(32'h100, 1);
            set_ex(1, 32'h100, 1, 0, 3'b001, 1, 1, 0);
            sb.push_back('{name: "recovery_bne", val: pk(1, 2'b11, 1, e_br, e_mis)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
            e_br++; e_mis++;
            idle();
            set_if(32'h100, 1);
            sb.push_back('{name: "recovery_lookup",
                           val: (k == 0) ? pk(1, 2'b01, 0, e_br, e_mis) : pk(0, 2'b00, 0, e_br, e_mis)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
        end
    endtask

    task automatic test_jalr();
        for (int k = 0; k < 2; k++) begin
            idle();
            set_ex(1, 32'h104, 1, 0, 3'b000, 1, 1, 0);
            sb.push_back('{name: "jalr_train", val: pk(0, 2'b00, 0, e_br, e_mis)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
            e_br++;
        end
        idle();
        set_if(32'h104, 1);
        set_ex(1, 32'h100, 0, 1, 3'b000, 0, 1, 0);
        sb.push_back('{name: "jalr_priority", val: pk(1, 2'b10, 1, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "jalr_no_update", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
    endtask

    task automatic test_suppress();
        idle();
        set_if(32'h104, 1);
        set_ex(0, 32'h100, 1, 1, 3'b000, 0, 1, 0);
        sb.push_back('{name: "suppress_redirect", val: pk(1, 2'b01, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "suppress_no_update", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
    endtask

    task automatic test_collision();
        // 0x100 and 0x200 share index 0; entry is 01 here
        idle();
        set_if(32'h100, 1);
        set_ex(1, 32'h200, 1, 0, 3'b000, 1, 1, 0);
        sb.push_back('{name: "collision_old", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br++;
        idle();
        set_if(32'h100, 1);
        sb.push_back('{name: "collision_new", val: pk(1, 2'b01, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
    endtask

    task automatic test_funct3();
        logic t;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 4; c++) begin
                idle();
                set_ex(1, 32'h3F0, 1, 0, 3'(f), 0, c[1], c[0]);
                t = exp_taken(3'(f), c[1], c[0]);
                sb.push_back('{name: $sformatf("funct3_%0d_eq%0d_lt%0d", f, c[1], c[0]),
                               val: pk(0, t ? 2'b10 : 2'b00, t, e_br, e_mis)});
                #1; e = sb.pop_front(); total++;
                if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
                tick();
                e_br++;
                if (t) e_mis++;
            end
        end
    endtask

    task automatic test_stat_wrap();
        idle();
        bif.stat_clr = 1;
        sb.push_back('{name: "stat_clr_idle", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br = 0; e_mis = 0;
        for (int k = 0; k < 17; k++) begin
            idle();
            set_ex(1, 32'h3F0, 1, 0, 3'b010, 0, 0, 0);
            sb.push_back('{name: "stat_count", val: pk(0, 2'b00, 0, e_br, 4'd0)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
            e_br++;
        end
        idle();
        sb.push_back('{name: "stat_wrapped", val: pk(0, 2'b00, 0, 4'd1, 4'd0)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        idle();
        bif.stat_clr = 1;
        set_ex(1, 32'h3F0, 1, 0, 3'b000, 0, 1, 0);
        sb.push_back('{name: "stat_clr_resolve", val: pk(0, 2'b10, 1, 4'd1, 4'd0)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br = 0; e_mis = 0;
        idle();
        sb.push_back('{name: "stat_clr_wins", val: pk(0, 2'b00, 0, 4'd0, 4'd0)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
    endtask

    task automatic test_midop_reset();
        idle();
        set_ex(1, 32'h104, 1, 0, 3'b000, 0, 1, 0);
        sb.push_back('{name: "midop_pre", val: pk(0, 2'b10, 1, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        e_br++; e_mis++;
        rst_n = 0;
        idle();
        set_if(32'h104, 1);
        set_ex(1, 32'h108, 1, 0, 3'b000, 0, 1, 0);
        sb.push_back('{name: "midop_forced", val: pk(0, 2'b00, 0, e_br, e_mis)});
        #1; e = sb.pop_front(); total++;
        if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
        tick();
        rst_n = 1;
        e_br = 0; e_mis = 0;
        for (int k = 0; k < 2; k++) begin
            idle();
            set_if((k == 0) ? 32'h104 : 32'h108, 1);
            sb.push_back('{name: "midop_table_init", val: pk(0, 2'b00, 0, e_br, e_mis)});
            #1; e = sb.pop_front(); total++;
            if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val); else passed++;
            tick();
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        e_br   = 0;
        e_mis  = 0;
        test_reset();
        test_training();
        test_recovery();
        test_jalr();
        test_suppress();
        test_collision();
        test_funct3();
        test_stat_wrap();
        test_midop_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised successor to the combinational branch/JALR PC-select logic. Adds a direct-mapped table of 2-bit saturating counters that predicts conditional branches in IF and resolves them in EX. It raises a redirect and flush on mispredict, and keeps branch and mispredict statistics. It drives the fetch next-PC mux select and the IF/ID flush.

## Interface
Parameters:
- `XLEN`, 32, PC width
- `IDX_BITS`, 6, table index width; the table has 2^IDX_BITS entries
- `CNT_INIT`, 2'b01, counter value at reset (weakly not-taken)
- `STAT_W`, 32, statistics counter width

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `if_pc`  in  XLEN  PC of the instruction in IF
- `if_is_branch`  in  1  predecode: IF instruction is a conditional branch
- `pred_taken`  out  1  prediction for the IF instruction; carried down the pipe to `ex_pred_taken`
- `ex_valid`  in  1  EX holds a valid (non-bubble) instruction
- `ex_pc`  in  XLEN  PC of the EX instruction
- `ex_is_branch`  in  1  EX instruction is a conditional branch (opcode 1100011)
- `ex_is_jalr`  in  1  EX instruction is JALR
- `ex_funct3`  in  3  branch funct3
- `ex_pred_taken`  in  1  prediction made for this instruction in IF
- `BrEq`, `BrLt`  in  1 each  branch comparator outputs; signedness is selected upstream
- `PCSel`  out  2  next-PC select: 00 = IF PC+4; 01 = IF predicted branch target; 10 = EX ALU target; 11 = EX PC+4 (recovery)
- `flush`  out  1  kill the IF/ID instructions
- `stat_clr`  in  1  clear the statistics counters
- `stat_branches`  out  STAT_W  count of resolved conditional branches
- `stat_mispredicts`  out  STAT_W  count of mispredicted conditional branches

## Operation
- Index: `idx(pc) = pc[IDX_BITS+1:2]`. No tag; aliasing is accepted.
- Predict: `pred_taken = if_is_branch & table[idx(if_pc)][1]`.
- Resolve, when `ex_valid & ex_is_branch`:
  - funct3 000 → taken = BrEq
  - 001 → taken = ~BrEq
  - 100 or 110 → taken = BrLt
  - 101 or 111 → taken = ~BrLt
  - 010 or 011 → taken = 0
- `mispredict = ex_valid & ex_is_branch & (taken != ex_pred_taken)`.
- PCSel priority, highest first:
  1. `ex_valid & ex_is_jalr` → 10
  2. mispredict with taken=1 → 10
  3. mispredict with taken=0 → 11
  4. `pred_taken` → 01
  5. otherwise → 00
- `flush = PCSel[1]`.
- Table update on each resolved branch: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00. Only `table[idx(ex_pc)]` changes.
- JALR and non-branches never update the table or the statistics.
- Statistics:
  - `stat_branches` increments on every resolved branch.
  - `stat_mispredicts` increments on every mispredict.
  - Both wrap modulo 2^STAT_W.
  - `stat_clr` zeroes both and takes priority over an increment in the same cycle.

## Timing
- `pred_taken`, `PCSel` and `flush` are combinational, same cycle as their inputs.
- Table and statistics writes take effect at the rising edge. A write is visible to predictions from the next cycle on.
- Same-cycle read and write of one index: IF sees the old counter value; there is no bypass.
- While `rst_n` = 0:
  - every table entry loads `CNT_INIT` at the edge;
  - the statistics load 0;
  - `PCSel` = 00, `flush` = 0 and `pred_taken` = 0, forced combinationally.
- Reset asserted mid-operation discards any pending update in that cycle.
- `ex_valid` = 0 suppresses resolution, updates and redirects, regardless of the other EX inputs.
- Redirect latency: a mispredict in EX sets PCSel and flush in the same cycle. The penalty is 2 cycles (IF and ID squashed).

## Test plan
- Reset then branch lookup: hold `rst_n`=0 for 1 cycle, release. Present BEQ at `if_pc`=0x100 → `pred_taken`=0, PCSel=00, both statistics = 0.
- Training: resolve BEQ at `ex_pc`=0x100 three times with BrEq=1 and ex_pred_taken=0.
  - Counter steps 01→10→11, saturating.
  - Next IF lookup of 0x100 → `pred_taken`=1, PCSel=01.
  - `stat_mispredicts`=3.
- Recovery: BNE with ex_pred_taken=1 and BrEq=1 → PCSel=11, flush=1, counter decrements by one. With `if_is_branch`=1 on an entry predicting taken in the same cycle, EX still wins.
- JALR priority: `ex_is_jalr`=1 with an IF prediction of taken → PCSel=10, flush=1, table and statistics unchanged.
- Aliasing and collision (IDX_BITS=6): PCs 0x100 and 0x200 map to the same index. A write and read of that index in the same cycle → IF returns the old value; the new value is seen the next cycle.
- Statistics: with STAT_W=4, resolve 17 branches → `stat_branches`=1 after wrap. Asserting `stat_clr` together with a resolving branch → counters = 0.
